plane_stepper: RTL and testbench
================================

Name: plane_stepper

Overview:
- Consumer of plane-equation coefficients (FDDX, FDDY, c) produced by PVR triangle setup.
- Walks one screen tile in raster order using add-only incremental stepping.
- Emits a valid/ready stream of per-pixel interpolated values (Z, U, V, colour channel) into the pixel pipeline.
- Each output is bit-exact to the direct form x*FDDX + y*FDDY + c; it replaces a per-pixel multiplier with two adders.

Parameters:
- TILE_W, 32, pixels per tile row (power of two, 2..64).
- TILE_H, 32, tile rows (power of two, 2..64).
- ACC_W, 48, accumulator width; matches the 48-bit width of c.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- coef_ddx  in  32  signed per-pixel X gradient.
- coef_ddy  in  32  signed per-pixel Y gradient.
- coef_c  in  48  signed plane constant.
- tile_x  in  11  tile origin X in pixels (multiple of TILE_W).
- tile_y  in  11  tile origin Y in pixels (multiple of TILE_H).
- busy  out  1  high from start acceptance until the DONE cycle ends.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the pixel pipeline.
- out_value  out  32  signed interpolated value; low 32 bits of the accumulator.
- out_x  out  11  pixel X of the current beat.
- out_y  out  11  pixel Y of the current beat.
- out_last  out  1  high on the final beat of the tile.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators 0.
- The async assert of reset_n takes effect immediately. Deassertion is synchronised externally.
- Reset mid-tile abandons the tile; no done pulse is generated.
- States and transitions:
  - IDLE: on start=1, latch the coefficients and origin, set busy=1, go to SETUP. start in any other state is ignored; no queuing.
  - SETUP (1 cycle): row_base = c + sext(tile_x)*ddx + sext(tile_y)*ddy, computed modulo 2^ACC_W. Set acc = row_base, cx=0, cy=0. Go to RUN.
  - RUN: out_valid=1. out_value = acc[31:0], out_x = tile_x+cx, out_y = tile_y+cy.
    - A beat is accepted when out_valid & out_ready.
    - On acceptance with cx < TILE_W-1: acc += sext(ddx), cx++.
    - On acceptance with cx == TILE_W-1 and cy < TILE_H-1: row_base += sext(ddy), acc = row_base + sext(ddy), cx=0, cy++.
    - On acceptance at the last pixel: go to DONE.
  - DONE (1 cycle): done=1, out_valid=0; busy drops at the end of this cycle. Return to IDLE.
- Latency: first beat valid 2 cycles after the start cycle. With out_ready held high, throughput is 1 pixel/clock and the tile takes TILE_W*TILE_H cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_value, out_x, out_y and out_last must hold stable. out_valid never drops until the beat is accepted.
- Arithmetic: two's-complement with wrap at ACC_W; no saturation.
  - Required invariant for every beat: out_value == (x*ddx + y*ddy + c) mod 2^32, sign-reinterpreted.
  - Edge wrap (tile_x=2016 with TILE_W=32) has no special case; out_x reaches 2047.
- Coefficient inputs are sampled only on the accepted start cycle. Changing them later has no effect on the tile in progress.
- out_last = 1 only when cx==TILE_W-1 and cy==TILE_H-1 in RUN.

Optional Feature:
- Macro: PLANE_STEPPER_CHECK_EN.
- When defined:
  - Adds a direct-form multiplier that evaluates x*ddx + y*ddy + c for the current beat.
  - Adds output port check_err (1 bit, reset 0). It is sticky-set when an accepted beat's out_value differs from the direct-form result. It is cleared only by reset or by an accepted start.
- When undefined: no multiplier and no check_err port; behaviour is otherwise identical.

Decomposition:
- Shared package pvr_interp_pkg holds:
  - COEF_W=32, ACC_W_DEF=48, COORD_W=11, TILE_DIM_DEF=32.
  - Typedefs coef_t (signed 32), acc_t (signed 48), coord_t (11-bit unsigned).
  - State enum ps_state_t {IDLE, SETUP, RUN, DONE}.
- One natural sub-module: plane_stepper_origin. It is the combinational origin multiply-add used in SETUP and is reused by the checker under PLANE_STEPPER_CHECK_EN.

Test Plan:
- ddx=1, ddy=32, c=0, tile (0,0), out_ready=1 → values 0..1023 in order; out_last on beat 1023; done at cycle 1026 after start.
- ddx=-3, ddy=5, c=0x0000_0000_1000, tile (64,32) → first value 4096-192+160=4064; last value 4064-93+155=4126.
- Random out_ready (50%) with ddx=0x7FFF_FFFF, ddy=-1, c=2^47-1 → every beat matches the direct-form model mod 2^32; outputs stay stable while stalled; no beats dropped or duplicated.
- Pulse start again at beat 10 with different coefficients → ignored; the tile completes with the original coefficients; the following start in IDLE is accepted.
- Assert reset_n low at beat 500 → out_valid, busy, done and out_value are 0 immediately; no done pulse; a new start after release produces a full correct tile.
- With PLANE_STEPPER_CHECK_EN and ddx=7, ddy=-2, c=100, tile (2016,448) → check_err stays 0; force acc corruption → check_err=1 and stays set until the next start.

Source files
------------

// File: rtl/pvr_interp_pkg.sv
// rtl/pvr_interp_pkg.sv - shared widths, types and stepper states for PVR plane interpolation
package pvr_interp_pkg;

    localparam int COEF_W       = 32;
    localparam int ACC_W_DEF    = 48;
    localparam int COORD_W      = 11;
    localparam int TILE_DIM_DEF = 32;

    typedef logic signed [COEF_W-1:0]    coef_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;
    typedef logic        [COORD_W-1:0]   coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } ps_state_t;

endpackage

// File: rtl/plane_stepper_origin.sv
// rtl/plane_stepper_origin.sv - combinational direct-form plane evaluation c + x*ddx + y*ddy
module plane_stepper_origin
    import pvr_interp_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  coef_t                    ddx,
    input  coef_t                    ddy,
    input  logic signed [ACC_W-1:0]  c,
    input  coord_t                   x,
    input  coord_t                   y,
    output logic signed [ACC_W-1:0]  result
);

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] y_ext;
    logic signed [ACC_W-1:0] ddx_ext;
    logic signed [ACC_W-1:0] ddy_ext;

    // Pixel coordinates are magnitudes, so they widen without sign so that x=2047 stays 2047.
    assign x_ext   = {{(ACC_W-COORD_W){1'b0}}, x};
    assign y_ext   = {{(ACC_W-COORD_W){1'b0}}, y};
    assign ddx_ext = {{(ACC_W-COEF_W){ddx[COEF_W-1]}}, ddx};
    assign ddy_ext = {{(ACC_W-COEF_W){ddy[COEF_W-1]}}, ddy};

    assign result = c + x_ext * ddx_ext + y_ext * ddy_ext;

endmodule

// File: rtl/plane_stepper.sv
// rtl/plane_stepper.sv - add-only raster tile walker for plane equations; PLANE_STEPPER_CHECK_EN adds a direct-form checker
module plane_stepper
    import pvr_interp_pkg::*;
#(
    parameter int TILE_W = TILE_DIM_DEF,
    parameter int TILE_H = TILE_DIM_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic signed [COEF_W-1:0]  coef_ddx,
    input  logic signed [COEF_W-1:0]  coef_ddy,
    input  logic signed [47:0]        coef_c,
    input  logic [COORD_W-1:0]        tile_x,
    input  logic [COORD_W-1:0]        tile_y,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COEF_W-1:0]  out_value,
    output logic [COORD_W-1:0]        out_x,
    output logic [COORD_W-1:0]        out_y,
    output logic                      out_last,
    output logic                      done
`ifdef PLANE_STEPPER_CHECK_EN
    ,
    output logic                      check_err
`endif
);

    localparam int CX_W = $clog2(TILE_W);
    localparam int CY_W = $clog2(TILE_H);
    localparam logic [CX_W-1:0] CX_MAX = CX_W'(TILE_W - 1);
    localparam logic [CY_W-1:0] CY_MAX = CY_W'(TILE_H - 1);

    ps_state_t               state_q, state_d;
    coef_t                   ddx_q, ddy_q;
    logic signed [ACC_W-1:0] c_q;
    coord_t                  tile_x_q, tile_y_q;
    logic signed [ACC_W-1:0] acc, row_base, origin;
    logic signed [ACC_W-1:0] ddx_ext, ddy_ext;
    logic [CX_W-1:0]         cx;
    logic [CY_W-1:0]         cy;
    logic                    accept, row_end, at_last;

    assign ddx_ext = ACC_W'(ddx_q);
    assign ddy_ext = ACC_W'(ddy_q);
    assign accept  = (state_q == RUN) && out_ready;
    assign row_end = (cx == CX_MAX);
    assign at_last = row_end && (cy == CY_MAX);

    plane_stepper_origin #(.ACC_W(ACC_W)) u_origin (
        .ddx    (ddx_q),
        .ddy    (ddy_q),
        .c      (c_q),
        .x      (tile_x_q),
        .y      (tile_y_q),
        .result (origin)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        out_valid = 1'b0;
        out_value = '0;
        out_x     = '0;
        out_y     = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: state_d = RUN;
            RUN: begin
                out_valid = 1'b1;
                out_value = acc[COEF_W-1:0];
                out_x     = tile_x_q + COORD_W'(cx);
                out_y     = tile_y_q + COORD_W'(cy);
                out_last  = at_last;
                if (accept && at_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Each row restarts from row_base so column steps never accumulate across rows.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ddx_q    <= '0;
            ddy_q    <= '0;
            c_q      <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
            acc      <= '0;
            row_base <= '0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ddx_q    <= coef_ddx;
                        ddy_q    <= coef_ddy;
                        c_q      <= ACC_W'(coef_c);
                        tile_x_q <= tile_x;
                        tile_y_q <= tile_y;
                    end
                end
                SETUP: begin
                    acc      <= origin;
                    row_base <= origin;
                    cx       <= '0;
                    cy       <= '0;
                end
                RUN: begin
                    if (accept && !row_end) begin
                        acc <= acc + ddx_ext;
                        cx  <= cx + 1'b1;
                    end else if (accept && !at_last) begin
                        row_base <= row_base + ddy_ext;
                        acc      <= row_base + ddy_ext;
                        cx       <= '0;
                        cy       <= cy + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PLANE_STEPPER_CHECK_EN
    logic signed [ACC_W-1:0] direct;

    plane_stepper_origin #(.ACC_W(ACC_W)) u_check (
        .ddx    (ddx_q),
        .ddy    (ddy_q),
        .c      (c_q),
        .x      (out_x),
        .y      (out_y),
        .result (direct)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            check_err <= 1'b0;
        end else if (state_q == IDLE && start) begin
            check_err <= 1'b0;
        end else if (accept && (32'(direct) != out_value)) begin
            check_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_plane_stepper.sv
// tb/tb_plane_stepper.sv - scoreboard bench for plane_stepper against a direct-form model
module tb_plane_stepper;

    localparam int TW = 32;
    localparam int TH = 32;

    typedef struct {
        logic [31:0] v;
        logic [10:0] x;
        logic [10:0] y;
        logic        last;
    } beat_t;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               start;
    logic signed [31:0] coef_ddx, coef_ddy;
    logic signed [47:0] coef_c;
    logic [10:0]        tile_x, tile_y;
    logic               busy, out_valid, out_ready, out_last, done;
    logic [31:0]        out_value;
    logic [10:0]        out_x, out_y;
`ifdef PLANE_STEPPER_CHECK_EN
    logic               check_err;
`endif

    plane_stepper dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .coef_ddx  (coef_ddx),
        .coef_ddy  (coef_ddy),
        .coef_c    (coef_c),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .done      (done)
`ifdef PLANE_STEPPER_CHECK_EN
        ,
        .check_err (check_err)
`endif
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    beat_count = 0;
    bit    mon_en = 0;
    bit    ready_random = 0;
    bit    hold_pending = 0;
    beat_t held;
    beat_t expq[$];
    logic [31:0] first_val, last_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_tile(input logic signed [31:0] ddx, input logic signed [31:0] ddy,
                             input logic signed [47:0] c, input logic [10:0] tx, input logic [10:0] ty);
        for (int yy = 0; yy < TH; yy++) begin
            for (int xx = 0; xx < TW; xx++) begin
                beat_t  b;
                longint px, py, v;
                px = longint'(tx) + xx;
                py = longint'(ty) + yy;
                v  = px * longint'(ddx) + py * longint'(ddy) + longint'(c);
                b.v    = v[31:0];
                b.x    = px[10:0];
                b.y    = py[10:0];
                b.last = (xx == TW - 1) && (yy == TH - 1);
                expq.push_back(b);
            end
        end
    endtask

    task automatic start_tile(input logic signed [31:0] ddx, input logic signed [31:0] ddy,
                              input logic signed [47:0] c, input logic [10:0] tx, input logic [10:0] ty,
                              output int scyc);
        push_tile(ddx, ddy, c, tx, ty);
        beat_count = 0;
        @(posedge clock); #1;
        coef_ddx = ddx; coef_ddy = ddy; coef_c = c; tile_x = tx; tile_y = ty;
        start = 1'b1;
        scyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        coef_ddx = $urandom; coef_ddy = $urandom; coef_c = {$urandom, $urandom} ;
        tile_x = 11'($urandom); tile_y = 11'($urandom);
        check("busy_setup", 64'(busy), 64'd1);
        check("valid_setup", 64'(out_valid), 64'd0);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n = 0;
        dcyc = -1;
        while (n < budget) begin
            @(negedge clock);
            if (done) begin
                dcyc = cyc;
                break;
            end
            n++;
        end
        check("done_seen", 64'(dcyc >= 0), 64'd1);
        if (dcyc >= 0) begin
            @(negedge clock);
            check("done_pulse", 64'(done), 64'd0);
            check("busy_after", 64'(busy), 64'd0);
            check("queue_empty", 64'(expq.size()), 64'd0);
        end
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_count < n && k < 5000) begin
            @(negedge clock);
            k++;
        end
        check("reach_beat", 64'(beat_count >= n), 64'd1);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            out_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            if (hold_pending) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_value", 64'(out_value), 64'(held.v));
                check("stall_x", 64'(out_x), 64'(held.x));
                check("stall_y", 64'(out_y), 64'(held.y));
                check("stall_last", 64'(out_last), 64'(held.last));
            end
            hold_pending = 0;
            if (out_valid && out_ready) begin
                check("beat_expected", 64'(expq.size() > 0), 64'd1);
                if (expq.size() > 0) begin
                    beat_t b;
                    b = expq.pop_front();
                    check("value", 64'(out_value), 64'(b.v));
                    check("x", 64'(out_x), 64'(b.x));
                    check("y", 64'(out_y), 64'(b.y));
                    check("last", 64'(out_last), 64'(b.last));
                    if (beat_count == 0) first_val = out_value;
                    if (out_last) last_val = out_value;
                    beat_count++;
                end
            end else if (out_valid) begin
                hold_pending = 1;
                held.v = out_value; held.x = out_x; held.y = out_y; held.last = out_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, d;
        reset_n = 1'b0; start = 1'b0;
        coef_ddx = '0; coef_ddy = '0; coef_c = '0; tile_x = '0; tile_y = '0;
        repeat (3) @(negedge clock);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_value", 64'(out_value), 64'd0);
        check("rst_x", 64'(out_x), 64'd0);
        check("rst_y", 64'(out_y), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        reset_n = 1'b1;
        mon_en = 1;

        start_tile(32'sd1, 32'sd32, 48'sd0, 11'd0, 11'd0, s);
        wait_done(3000, d);
        check("t1_latency", 64'(d - s), 64'd1026);
        check("t1_beats", 64'(beat_count), 64'd1024);
        check("t1_first", 64'(first_val), 64'd0);
        check("t1_last", 64'(last_val), 64'd1023);

        start_tile(-32'sd3, 32'sd5, 48'h0000_0000_1000, 11'd64, 11'd32, s);
        wait_done(3000, d);
        check("t2_first", 64'(first_val), 64'd4064);
        check("t2_last", 64'(last_val), 64'd4126);

        ready_random = 1;
        start_tile(32'sh7FFF_FFFF, -32'sd1, 48'sh7FFF_FFFF_FFFF, 11'd2016, 11'd448, s);
        wait_done(8000, d);
        check("t3_beats", 64'(beat_count), 64'd1024);
        ready_random = 0;

        start_tile(32'sd2, 32'sd3, 48'sd5, 11'd32, 11'd0, s);
        wait_beats(10);
        @(posedge clock); #1;
        coef_ddx = 32'sd100; coef_ddy = -32'sd77; coef_c = 48'sd999; tile_x = 11'd512; tile_y = 11'd256;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(3000, d);
        check("t4_beats", 64'(beat_count), 64'd1024);
        start_tile(-32'sd7, 32'sd11, -48'sd1234, 11'd96, 11'd64, s);
        wait_done(3000, d);
        check("t4b_beats", 64'(beat_count), 64'd1024);

        start_tile(32'sd5, -32'sd9, 48'h0001_2345_6789, 11'd0, 11'd992, s);
        wait_beats(500);
        @(negedge clock); #2;
        mon_en = 0;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_value", 64'(out_value), 64'd0);
        expq.delete();
        hold_pending = 0;
        repeat (4) begin
            @(negedge clock);
            check("arst_no_done", 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        mon_en = 1;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_idle_done", 64'(done), 64'd0);
        end
        start_tile(32'sd7, -32'sd2, 48'sd100, 11'd2016, 11'd448, s);
        wait_done(3000, d);
        check("t5_latency", 64'(d - s), 64'd1026);
        check("t5_beats", 64'(beat_count), 64'd1024);
`ifdef PLANE_STEPPER_CHECK_EN
        check("check_err_clean", 64'(check_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
